alu16_seq_ctrl: RTL and testbench
=================================

Name: alu16_seq_ctrl

Overview:
- Multi-cycle sequencer that executes one register-to-register instruction at a time on the shared register file and the ALU16 datapath.
- Accepts an instruction (op, rd, ra, rb) over a valid/ready handshake, then reads both operands, drives the ALU, writes the result back and latches the ALU status flags.
- Sits between the instruction source (test driver or future decode stage) and the regfile/ALU pair.

Parameters:
- DATA_W, 16, datapath width; must match the ALU and the regfile.
- ADDR_W, 4, regfile address width (16 registers).
- OP_W, 4, ALU select width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  controller can accept.
- instr_op  in  OP_W  ALU select code.
- instr_rd  in  ADDR_W  destination register.
- instr_ra  in  ADDR_W  source register for A.
- instr_rb  in  ADDR_W  source register for B.
- rf_raddr_a  out  ADDR_W  regfile read address, port A.
- rf_raddr_b  out  ADDR_W  regfile read address, port B.
- rf_rdata_a  in  DATA_W  read data A, valid one cycle after address.
- rf_rdata_b  in  DATA_W  read data B, valid one cycle after address.
- rf_we  out  1  regfile write enable.
- rf_waddr  out  ADDR_W  write address.
- rf_wdata  out  DATA_W  write data.
- alu_a  out  DATA_W  ALU operand A, registered.
- alu_b  out  DATA_W  ALU operand B, registered.
- alu_sel  out  OP_W  ALU select, registered.
- alu_out  in  DATA_W  ALU result, combinational.
- alu_n, alu_l, alu_z, alu_c, alu_f  in  1 each  ALU flags: negative, unsigned less, zero, signed overflow, unsigned carry/borrow.
- flags  out  5  latched {N,L,Z,C,F}.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high whenever state is not IDLE.
- op_err  out  1  one-cycle pulse on an illegal opcode.
- ovf_trap  out  1  one-cycle overflow-trap pulse; see Optional Feature.

Behaviour:
- Legal opcodes:
  - 0000 XOR
  - 0010 XNOR
  - 0100 ADD
  - 0101 SUB
  - 0111 NOT A (B is read but ignored)
  - 1000 AND
  - 1010 OR
- All other opcodes are illegal.
- Reset (async, rst_n=0): state=IDLE. All outputs 0 except instr_ready=1. flags=0, alu_a/alu_b/alu_sel=0. Any in-flight instruction is discarded and no write occurs.
- FSM states and transitions:
  - IDLE: instr_ready=1. On instr_valid&instr_ready, latch op/rd/ra/rb. Legal op -> READ; illegal op -> ERR.
  - READ: rf_raddr_a=ra_q, rf_raddr_b=rb_q. Unconditionally -> EXEC. At the transition edge, alu_a<=rf_rdata_a, alu_b<=rf_rdata_b, alu_sel<=op_q.
  - EXEC: ALU evaluates. Unconditionally -> WB. At the transition edge, result_q<=alu_out and flags<={alu_n,alu_l,alu_z,alu_c,alu_f}.
  - WB: rf_we=1, rf_waddr=rd_q, rf_wdata=result_q, done=1. -> IDLE.
  - ERR: op_err=1, done=1, rf_we=0, flags unchanged. -> IDLE.
- Latency and throughput:
  - Legal op: accept edge T0; done is high in the cycle after edge T2 (3 cycles after accept). One instruction per 4 cycles.
  - Illegal op: done is high 1 cycle after accept.
- instr_ready is low outside IDLE; instr_valid there is ignored. No skid buffering.
- Instruction fields are sampled only at the accept edge; later changes on the input bus have no effect.
- rd may equal ra or rb. The write occurs after both reads, so there is no hazard.
- rf_raddr_* hold their last value outside READ; rf_waddr/rf_wdata are don't-care when rf_we=0.
- flags hold between instructions and update only in EXEC->WB.

Optional Feature:
- Macro: ALU_OVF_TRAP_EN.
- Defined: for ADD/SUB, if alu_c=1 when EXEC->WB is taken:
  - WB still pulses done.
  - rf_we is forced 0 (destination unchanged).
  - ovf_trap=1 for that cycle.
  - flags still update.
  - Logic ops never trap.
- Undefined: ovf_trap is tied 0 and the write-back is always performed.

Test Plan:
- ADD: r1=69, r2=55, op 0100, rd=r3 -> done 3 cycles after accept; r3=0x007C; flags N=0 Z=0 C=0 F=0.
- SUB: r1=0xFFF6 (-10), r2=55, op 0101 -> rd=0xFFBF (-65); N=1, C=0.
- ADD overflow: r1=16384, r2=16394 -> alu_out=0x800A, C=1.
  - Without ALU_OVF_TRAP_EN: rd=0x800A written.
  - With it: rd unchanged, ovf_trap pulse, done pulse.
- Logic ops:
  - AND 15&2 -> 0x0002.
  - NOT A with A=0 -> 0xFFFF, N=1.
  - XOR 100^185 -> 0x00DD.
  - Back-to-back: instr_valid held high, next accept exactly 4 cycles after the previous one.
- Illegal op 0001 -> op_err and done pulse 1 cycle after accept; rf_we never asserted; flags unchanged.
- Reset: rst_n=0 asynchronously during EXEC -> outputs at reset values immediately; rf_we never asserted; after release instr_ready=1 and the next instruction completes normally.

Source files
------------

// File: rtl/alu16_seq_ctrl.sv
// rtl/alu16_seq_ctrl.sv - multi-cycle regfile/ALU instruction sequencer; optional overflow trap via ALU_OVF_TRAP_EN
module alu16_seq_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_ra,
    input  logic [ADDR_W-1:0] instr_rb,
    output logic [ADDR_W-1:0] rf_raddr_a,
    output logic [ADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_n,
    input  logic              alu_l,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_f,
    output logic [4:0]        flags,
    output logic              done,
    output logic              busy,
    output logic              op_err,
    output logic              ovf_trap
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            OP_W'(4'h0), OP_W'(4'h2), OP_W'(4'h4), OP_W'(4'h5),
            OP_W'(4'h7), OP_W'(4'h8), OP_W'(4'hA): legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic                instr_ready_q, instr_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                op_err_q, op_err_d;
    logic                ovf_trap_q, ovf_trap_d;
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_raddr_a_q, rf_raddr_a_d;
    logic [ADDR_W-1:0]   rf_raddr_b_q, rf_raddr_b_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_sel_q, alu_sel_d;
    logic [4:0]          flags_q, flags_d;

`ifdef ALU_OVF_TRAP_EN
    logic op_is_addsub;
    assign op_is_addsub = (op_q == OP_W'(4'h4)) || (op_q == OP_W'(4'h5));
`endif

    // Next-state and registered-output computation; rf_wdata_q doubles as the latched ALU result
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rd_d          = rd_q;
        instr_ready_d = instr_ready_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        op_err_d      = 1'b0;
        ovf_trap_d    = 1'b0;
        rf_we_d       = 1'b0;
        rf_raddr_a_d  = rf_raddr_a_q;
        rf_raddr_b_d  = rf_raddr_b_q;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sel_d     = alu_sel_q;
        flags_d       = flags_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d          = instr_op;
                    rd_d          = instr_rd;
                    rf_raddr_a_d  = instr_ra;
                    rf_raddr_b_d  = instr_rb;
                    instr_ready_d = 1'b0;
                    busy_d        = 1'b1;
                    if (op_is_legal(instr_op)) begin
                        state_d = S_READ;
                    end else begin
                        state_d  = S_ERR;
                        op_err_d = 1'b1;
                        done_d   = 1'b1;
                    end
                end
            end
            S_READ: begin
                alu_a_d   = rf_rdata_a;
                alu_b_d   = rf_rdata_b;
                alu_sel_d = op_q;
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                rf_wdata_d = alu_out;
                flags_d    = {alu_n, alu_l, alu_z, alu_c, alu_f};
                rf_waddr_d = rd_q;
                rf_we_d    = 1'b1;
                done_d     = 1'b1;
`ifdef ALU_OVF_TRAP_EN
                if (op_is_addsub && alu_c) begin
                    rf_we_d    = 1'b0;
                    ovf_trap_d = 1'b1;
                end
`endif
                state_d = S_WB;
            end
            S_WB, S_ERR: begin
                instr_ready_d = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
            default: begin
                instr_ready_d = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            rd_q          <= '0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            op_err_q      <= 1'b0;
            ovf_trap_q    <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_raddr_a_q  <= '0;
            rf_raddr_b_q  <= '0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_sel_q     <= '0;
            flags_q       <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            instr_ready_q <= instr_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            op_err_q      <= op_err_d;
            ovf_trap_q    <= ovf_trap_d;
            rf_we_q       <= rf_we_d;
            rf_raddr_a_q  <= rf_raddr_a_d;
            rf_raddr_b_q  <= rf_raddr_b_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sel_q     <= alu_sel_d;
            flags_q       <= flags_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign op_err      = op_err_q;
    assign ovf_trap    = ovf_trap_q;
    assign rf_we       = rf_we_q;
    assign rf_raddr_a  = rf_raddr_a_q;
    assign rf_raddr_b  = rf_raddr_b_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign flags       = flags_q;

endmodule

// File: tb/tb_alu16_seq_ctrl.sv
// tb/tb_alu16_seq_ctrl.sv - scoreboard bench for alu16_seq_ctrl with regfile/ALU models
module tb_alu16_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op, instr_rd, instr_ra, instr_rb;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_n, alu_l, alu_z, alu_c, alu_f;
    logic [4:0]  flags;
    logic        done, busy, op_err, ovf_trap;

    always #5 clk = ~clk;

    alu16_seq_ctrl #(.DATA_W(16), .ADDR_W(4), .OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .alu_n(alu_n), .alu_l(alu_l), .alu_z(alu_z), .alu_c(alu_c), .alu_f(alu_f),
        .flags(flags), .done(done), .busy(busy), .op_err(op_err), .ovf_trap(ovf_trap)
    );

    typedef struct packed {
        logic [15:0] res;
        logic n, l, z, c, f;
    } alu_res_t;

    // ALU behaviour from plain integer arithmetic: C = signed overflow, F = unsigned carry/borrow
    function automatic alu_res_t ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        alu_res_t o;
        int ua, ub, sa, sb, r, sr;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        o = '0;
        case (op)
            4'h0: o.res = a ^ b;
            4'h2: o.res = ~(a ^ b);
            4'h4: begin
                r = ua + ub; sr = sa + sb;
                o.res = r[15:0];
                o.f = (r > 65535);
                o.c = (sr > 32767) || (sr < -32768);
            end
            4'h5: begin
                r = ua - ub; sr = sa - sb;
                o.res = r[15:0];
                o.f = (ua < ub);
                o.c = (sr > 32767) || (sr < -32768);
            end
            4'h7: o.res = ~a;
            4'h8: o.res = a & b;
            4'hA: o.res = a | b;
            default: o.res = 16'h0000;
        endcase
        o.n = o.res[15];
        o.z = (o.res == 16'h0000);
        o.l = (ua < ub);
        return o;
    endfunction

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'h0, 4'h2, 4'h4, 4'h5, 4'h7, 4'h8, 4'hA};
    endfunction

    // Environment: combinational ALU and regfile with async read
    alu_res_t alu_r;
    always_comb alu_r = ref_alu(alu_sel, alu_a, alu_b);
    assign alu_out = alu_r.res;
    assign alu_n = alu_r.n;
    assign alu_l = alu_r.l;
    assign alu_z = alu_r.z;
    assign alu_c = alu_r.c;
    assign alu_f = alu_r.f;

    logic [15:0] rf [16];
    logic        tb_we = 1'b0;
    logic [3:0]  tb_waddr = 4'h0;
    logic [15:0] tb_wdata = 16'h0000;
    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];
    always @(posedge clk) begin
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        else if (tb_we) rf[tb_waddr] <= tb_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    typedef struct {
        bit          err;
        bit          we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic [4:0]  flg;
        bit          trap;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mrf [16];
    logic [4:0]  mflags = 5'b0;
    int          last_acc = 0;
    int          last_gap = 0;
    int          last_end_cyc = -10;
    bit          have_prev = 0;

    // Monitor: pops an expectation on every done pulse and checks protocol every cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("op_err", op_err, e.err);
                    chk("rf_we", rf_we, e.we);
                    if (e.we) begin
                        chk("rf_waddr", rf_waddr, e.waddr);
                        chk("rf_wdata", rf_wdata, e.wdata);
                    end
                    chk("flags", flags, e.flg);
                    chk("ovf_trap", ovf_trap, e.trap);
                    chk("latency", cyc - e.acc, e.err ? 0 : 2);
                end
            end else begin
                chk("no_stray_pulse", {rf_we, op_err, ovf_trap}, 3'b000);
            end
            chk("busy_vs_ready", busy, !instr_ready);
        end
    end

    task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
        mrf[a] = d;
    endtask

    // Drive one instruction from a negedge; the expected response is queued at acceptance
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        alu_res_t r;
        int k;
        bit b2b;
        b2b = have_prev && (cyc == last_end_cyc);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
        k = 0;
        while (!instr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!instr_ready) begin
            fail_now("accept");
            instr_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        if (b2b) chk("accept_gap", e.acc - last_acc, last_gap);
        e.err = !is_legal(op);
        e.waddr = rd;
        e.trap = 1'b0;
        if (e.err) begin
            e.we = 1'b0; e.wdata = 16'h0; e.flg = mflags;
        end else begin
            r = ref_alu(op, mrf[ra], mrf[rb]);
`ifdef ALU_OVF_TRAP_EN
            e.trap = (op == 4'h4 || op == 4'h5) && r.c;
`endif
            e.we = !e.trap;
            e.wdata = r.res;
            e.flg = {r.n, r.l, r.z, r.c, r.f};
            mflags = e.flg;
            if (e.we) mrf[rd] = r.res;
        end
        sb.push_back(e);
        last_acc = e.acc;
        last_gap = e.err ? 2 : 4;
        have_prev = 1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr_op = 4'($urandom); instr_rd = 4'($urandom); instr_ra = 4'($urandom); instr_rb = 4'($urandom);
        last_end_cyc = cyc;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(instr_ready && sb.size() == 0) && k < 20);
        if (!(instr_ready && sb.size() == 0)) fail_now("wait_idle");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [4:0]  fsave;
        logic [15:0] rsave;
        logic [3:0]  lops [7];
        lops = '{4'h0, 4'h2, 4'h4, 4'h5, 4'h7, 4'h8, 4'hA};
        rst_n = 1'b0;
        instr_valid = 1'b0; instr_op = 4'h0; instr_rd = 4'h0; instr_ra = 4'h0; instr_rb = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_ctrl", {busy, done, op_err, ovf_trap, rf_we}, 5'b0);
        chk("rst_flags", flags, 5'b0);
        chk("rst_alu", {alu_a, alu_b, alu_sel}, 36'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) set_reg(4'(i), 16'($urandom));

        // ADD 69+55
        set_reg(4'd1, 16'd69); set_reg(4'd2, 16'd55);
        issue(4'h4, 4'd3, 4'd1, 4'd2);
        wait_idle();
        chk("add_r3", rf[3], 16'h007C);
        chk("add_flags", flags, 5'b00000);
        // SUB -10-55
        set_reg(4'd1, 16'hFFF6);
        issue(4'h5, 4'd4, 4'd1, 4'd2);
        wait_idle();
        chk("sub_r4", rf[4], 16'hFFBF);
        chk("sub_n_c", {flags[4], flags[1]}, 2'b10);
        // ADD signed overflow
        set_reg(4'd5, 16'd16384); set_reg(4'd6, 16'd16394); set_reg(4'd7, 16'h1234);
        issue(4'h4, 4'd7, 4'd5, 4'd6);
        wait_idle();
`ifdef ALU_OVF_TRAP_EN
        chk("ovf_r7", rf[7], 16'h1234);
`else
        chk("ovf_r7", rf[7], 16'h800A);
`endif
        chk("ovf_c", flags[1], 1'b1);
        // Logic ops
        set_reg(4'd8, 16'd15); set_reg(4'd9, 16'd2); set_reg(4'd11, 16'd0);
        set_reg(4'd13, 16'd100); set_reg(4'd14, 16'd185);
        issue(4'h8, 4'd10, 4'd8, 4'd9);
        wait_idle();
        chk("and_r10", rf[10], 16'h0002);
        issue(4'h7, 4'd12, 4'd11, 4'd9);
        wait_idle();
        chk("not_r12", rf[12], 16'hFFFF);
        chk("not_n", flags[4], 1'b1);
        issue(4'h0, 4'd15, 4'd13, 4'd14);
        wait_idle();
        chk("xor_r15", rf[15], 16'h00DD);
        // Illegal opcode leaves flags and registers alone
        fsave = flags;
        issue(4'h1, 4'd3, 4'd1, 4'd2);
        wait_idle();
        chk("illegal_flags", flags, fsave);
        chk("illegal_r3", rf[3], 16'h007C);
        // Back-to-back, including an illegal op and rd==ra
        issue(4'h0, 4'd2, 4'd1, 4'd2);
        issue(4'hA, 4'd3, 4'd3, 4'd1);
        issue(4'hF, 4'd4, 4'd1, 4'd1);
        issue(4'h4, 4'd1, 4'd1, 4'd1);
        issue(4'h8, 4'd5, 4'd1, 4'd2);
        wait_idle();

        // Asynchronous reset during EXEC discards the instruction
        rsave = rf[6];
        instr_valid = 1'b1; instr_op = 4'h4; instr_rd = 4'd6; instr_ra = 4'd1; instr_rb = 4'd2;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", instr_ready, 1'b1);
        chk("arst_ctrl", {busy, done, op_err, ovf_trap, rf_we}, 5'b0);
        chk("arst_flags", flags, 5'b0);
        chk("arst_alu", {alu_a, alu_b, alu_sel}, 36'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mflags = 5'b0;
        chk("arst_r6", rf[6], rsave);
        @(negedge clk);
        chk("arst_ready_after", instr_ready, 1'b1);
        issue(4'h5, 4'd6, 4'd2, 4'd1);
        wait_idle();

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            logic [3:0] op;
            if ($urandom_range(0, 7) == 0) op = 4'($urandom);
            else op = lops[$urandom_range(0, 6)];
            issue(op, 4'($urandom), 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        wait_idle();
        for (int i = 0; i < 16; i++) chk("rf_final", rf[i], mrf[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
